// File: rtl/conv_acc.sv
// rtl/conv_acc.sv - pipelined convolution MAC with bias, rounding and saturation.
// Optional CONV_ACC_RELU_EN clamps negative results to zero after saturation.
module conv_acc #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_sum,
    input  logic                     save,
    input  logic [ADDR_W-1:0]        save_addr,
    input  logic                     finish,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     done,
    output logic                     ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // stage A: controls aligned with memory read data
    logic              en_a, save_a, fin_a;
    logic [ADDR_W-1:0] addr_a;
    // stage P: product and bias registered
    logic              en_p, save_p, fin_p, fin_q;
    logic [ADDR_W-1:0] addr_p;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] bias;
    logic signed [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0] prod_ext, bias_ext, sum, rnd;
    logic                    sat_hi, sat_lo;
    logic [DATA_W-1:0]       res;

    always_comb begin
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_BITS;
        sum      = acc + prod_ext + bias_ext;
        rnd      = (sum + HALF) >>> FRAC_BITS;
        sat_hi   = rnd > MAX_V;
        sat_lo   = rnd < MIN_V;
        if (sat_hi)
            res = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sat_lo)
            res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            res = rnd[DATA_W-1:0];
`ifdef CONV_ACC_RELU_EN
        if (res[DATA_W-1])
            res = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_a    <= 1'b0;
            save_a  <= 1'b0;
            fin_a   <= 1'b0;
            addr_a  <= '0;
            en_p    <= 1'b0;
            save_p  <= 1'b0;
            fin_p   <= 1'b0;
            fin_q   <= 1'b0;
            addr_p  <= '0;
            prod    <= '0;
            bias    <= '0;
            acc     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            en_a   <= en_sum;
            save_a <= save;
            fin_a  <= finish;
            addr_a <= save_addr;

            en_p   <= en_a;
            save_p <= save_a;
            fin_p  <= fin_a;
            addr_p <= addr_a;
            prod   <= en_a ? PROD_W'(s_data) * PROD_W'(w_data) : '0;
            if (save_a)
                bias <= b_data;

            // a save closes the window, so the coincident term lands in this result only
            if (save_p)
                acc <= '0;
            else if (en_p)
                acc <= acc + prod_ext;

            wr_en <= save_p;
            if (save_p) begin
                wr_addr <= addr_p;
                wr_data <= res;
                ovf     <= ovf | sat_hi | sat_lo;
            end

            fin_q <= fin_p;
            done  <= fin_p & ~fin_q;
        end
    end

endmodule
